// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial shifter with a one-word holding register for gapless streaming
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;

    assign din_ready = !hold_full_q;
    assign accept    = din_valid && din_ready;
    assign x_valid   = state_q == SHIFT;
    assign x         = x_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    assign last      = x_valid && cnt_q == CNT_LAST;
    assign busy      = x_valid || hold_full_q;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = SHIFT;
                sh_d    = din;
                cnt_d   = '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (hold_full_q) begin
                sh_d        = hold_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                sh_d = din;
            end else begin
                state_d = IDLE;
            end
        end else begin
            sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (accept) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: three serializer configurations checked every cycle against a bit-queue reference model
module tb_bit_serializer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dv [3];
    logic [7:0] dd [3];
    logic       rdy_o [3];
    logic       x_o [3];
    logic       xv_o [3];
    logic       last_o [3];
    logic       busy_o [3];
    bit         q [3][$];
    bit         acc [3];
    int         w [3]    = '{8, 8, 4};
    bit         msb [3]  = '{1'b1, 1'b0, 1'b0};
    bit         idle [3] = '{1'b0, 1'b1, 1'b0};
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .reset(reset), .din(dd[0]), .din_valid(dv[0]), .din_ready(rdy_o[0]),
        .x(x_o[0]), .x_valid(xv_o[0]), .last(last_o[0]), .busy(busy_o[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
        .clk(clk), .reset(reset), .din(dd[1]), .din_valid(dv[1]), .din_ready(rdy_o[1]),
        .x(x_o[1]), .x_valid(xv_o[1]), .last(last_o[1]), .busy(busy_o[1]));

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_c (
        .clk(clk), .reset(reset), .din(dd[2][3:0]), .din_valid(dv[2]), .din_ready(rdy_o[2]),
        .x(x_o[2]), .x_valid(xv_o[2]), .last(last_o[2]), .busy(busy_o[2]));

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[dut%0d] observed=%b expected=%b at %0t", tag, i, obs, exp, $time);
        end
    endtask

    // The model is a queue of bits still to appear on x: the head is the bit on x now,
    // more than one word queued means the holding register is occupied.
    task automatic tick(input logic r);
        reset = r;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            acc[i] = !r && dv[i] && q[i].size() <= w[i];
            if (r) q[i].delete();
            else begin
                if (q[i].size() > 0) void'(q[i].pop_front());
                if (acc[i])
                    for (int b = 0; b < w[i]; b++)
                        q[i].push_back(dd[i][msb[i] ? w[i] - 1 - b : b]);
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("x_valid", i, xv_o[i], q[i].size() > 0);
            chk("x", i, x_o[i], q[i].size() > 0 ? q[i][0] : idle[i]);
            chk("last", i, last_o[i], q[i].size() % w[i] == 1);
            chk("busy", i, busy_o[i], q[i].size() > 0);
            chk("din_ready", i, rdy_o[i], q[i].size() <= w[i]);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) tick(1'b0);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        dv[i] = 1'b1;
        dd[i] = d;
        acc[i] = 1'b0;
        for (int n = 0; n < 40 && !acc[i]; n++) tick(1'b0);
        chk("accept_timeout", i, acc[i], 1'b1);
        dv[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            dd[i] = 8'h00;
        end
        tick(1'b1);
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b1;
            dd[i] = 8'h5A;
        end
        tick(1'b1);
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        idle_cycles(3);
        send(0, 8'hA5);
        idle_cycles(10);
        send(0, 8'hAA);
        send(0, 8'h55);
        send(0, 8'hFF);
        idle_cycles(26);
        send(0, 8'hC3);
        send(0, 8'h3C);
        idle_cycles(2);
        tick(1'b1);
        idle_cycles(20);
        send(1, 8'h01);
        send(2, 8'h0A);
        idle_cycles(10);
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i] = $urandom_range(0, 3) != 0;
                dd[i] = 8'($urandom);
            end
            tick($urandom_range(0, 70) == 0);
        end
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        idle_cycles(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `x`, the serial input consumed by the downstream bit-pattern FSM. A one-word holding register lets back-to-back words stream with no idle cycle between them. When no word is being shifted, the block drives a fixed idle level so the downstream detector stays in its start state.

## Interface
- `WIDTH`, default 8: word width in bits; minimum 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `x` whenever `x_valid` is 0.

- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `din` input WIDTH: parallel word to serialize.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: block can accept a word this cycle.
- `x` output 1: current serial bit; feeds the detector's `x` input.
- `x_valid` output 1: `x` carries a data bit this cycle.
- `last` output 1: current bit is the final bit of its word.
- `busy` output 1: shifter active or holding register full.

## Operation
- Storage:
  - Shift register `sh` (WIDTH bits).
  - Bit counter `cnt`, width ceil(log2(WIDTH)).
  - Holding register `hold` (WIDTH bits) with flag `hold_full`.
  - State: IDLE or SHIFT.
- Transfer: a word is accepted on a rising edge where `din_valid` and `din_ready` are both 1.
- `din_ready` = !`hold_full`. It is combinational from registered state only and never depends on `din_valid`.
- IDLE, word accepted: load `din` straight into `sh`, set `cnt` = 0, go to SHIFT. `hold` stays empty.
- SHIFT, not on the last bit, word accepted: store the word in `hold` and set `hold_full`.
- SHIFT, on the last bit (`cnt` = WIDTH-1), at the edge:
  - If `hold_full`: move `hold` into `sh`, clear `hold_full`, set `cnt` = 0, stay in SHIFT.
  - Else if a word is accepted that edge: load `din` into `sh` directly, set `cnt` = 0, stay in SHIFT.
  - Else: go to IDLE.
- SHIFT, otherwise: advance `sh` by one position in the configured direction and increment `cnt`.
- Outputs:
  - `x` = `sh[WIDTH-1]` when MSB_FIRST, else `sh[0]`. Forced to IDLE_BIT in IDLE.
  - `x_valid` = (state == SHIFT).
  - `last` = SHIFT and `cnt` == WIDTH-1.
  - `busy` = SHIFT or `hold_full`.
- The holding register can only fill while SHIFT is active. IDLE with `hold_full` = 1 is unreachable; the verifier asserts this.
- Reset (synchronous; it wins over any simultaneous handshake):
  - State goes to IDLE; `cnt`, `sh` and `hold` clear to 0; `hold_full` clears to 0.
  - A word presented in the reset cycle is not accepted.
  - A reset mid-word discards both the partial word and the held word, with no flush.
- Reset values of outputs: `din_ready` 1, `x` IDLE_BIT, `x_valid` 0, `last` 0, `busy` 0.

## Timing
- Latency: word accepted at edge k (from IDLE) → its first bit on `x` in the cycle after edge k. Bit i of the shift order appears in cycle k+1+i.
- One word occupies exactly WIDTH consecutive `x_valid` cycles.
- Streaming: if the next word is accepted no later than the edge that ends the current word's last bit, output is gapless; `x_valid` stays 1 across the boundary.
- Throughput: sustained one word per WIDTH cycles. `din_ready` drops for at most WIDTH-1 cycles per held word.
- Outputs are registered-state derived and change only after rising edges, so the detector samples a stable bit on the following edge.

## Test plan
- Reset, then `din`=8'hA5 for one cycle (MSB_FIRST=1) → `x` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `x_valid`=1; `last` high only on the 8th; then IDLE with `x`=0 and `busy`=0.
- Back-to-back 8'hAA then 8'h55 with `din_valid` held high → 16 contiguous valid bits 10101010 01010101; `din_ready` low from the edge after the second accept until the AA→55 boundary; the downstream 1010 detector fires on its expected cycles.
- Third word 8'hFF presented while `hold_full`=1 → not accepted until `din_ready` returns to 1; no word lost or duplicated; output order AA, 55, FF.
- `reset`=1 during bit 3 of 8'hC3 with 8'h3C held → next cycle `x_valid`=0, `busy`=0, `din_ready`=1; no bit of either word is emitted afterwards.
- MSB_FIRST=0, `din`=8'h01 → `x` = 1,0,0,0,0,0,0,0; with WIDTH=4, `din`=4'b1010 → 4 valid cycles.
- `din_valid` high in the same cycle as `reset`, then low → no word shifted; `x_valid` stays 0.
